mse_batch_evaluator: RTL and testbench

MSE_BATCH_EVALUATOR -- requirements
Module: mse_batch_evaluator

---
 rtl/mse_batch_evaluator.sv | 151 +++++++++++++++
 tb/tb_mse_batch_evaluator.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mse_batch_evaluator.sv
// Batch MSE evaluator: per-candidate saturating sum of squared error against a
// reference stream, reported as the mean over 2^LOG_SAMPLES accepted samples.
module mse_batch_evaluator #(
  parameter int NUM_CAND    = 2,
  parameter int DATA_WL     = 12,
  parameter int LOG_SAMPLES = 10,
  parameter int WARMUP      = 32,
  parameter int ACC_WL      = 64,
  localparam int IDX_W      = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        in_valid,
  input  logic [NUM_CAND*DATA_WL-1:0] data_in,
  input  logic [DATA_WL-1:0]          data_ref,
  output logic [ACC_WL-1:0]           res_data,
  output logic [IDX_W-1:0]            res_idx,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        busy,
  output logic                        done,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_ACCUM  = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  localparam int                SQ_W      = 2*DATA_WL + 2;
  localparam int                WCNT_W    = 17;
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CAND - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [WCNT_W-1:0]      r_warm_cnt;
  logic [LOG_SAMPLES-1:0] r_samp_cnt;
  logic                   r_drain_cnt;
  logic [IDX_W-1:0]       r_res_idx;
  logic                   r_done;
  logic                   r_s1_valid;
  logic [SQ_W-1:0]        r_sq [NUM_CAND];
  logic [ACC_WL-1:0]      r_acc [NUM_CAND];
  logic [SQ_W-1:0]        w_sq [NUM_CAND];
  logic [ACC_WL-1:0]      w_acc_next [NUM_CAND];
  logic                   w_start_ok;
  logic                   w_accept;
  logic                   w_res_fire;
  logic                   w_last_fire;

  // Result handshake: res_valid is high for the whole OUTPUT state and res_data/res_idx
  // hold still until a cycle with res_valid & res_ready, which transfers one result.
  assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
  assign w_accept    = (r_state == S_ACCUM) && in_valid && !abort;
  assign w_res_fire  = (r_state == S_OUTPUT) && res_ready && !abort;
  assign w_last_fire = w_res_fire && (r_res_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_next_state = (WARMUP == 0) ? S_ACCUM : S_WARMUP;
        S_WARMUP: if (in_valid && (r_warm_cnt == WARM_LAST)) w_next_state = S_ACCUM;
        S_ACCUM:  if (in_valid && (r_samp_cnt == '1)) w_next_state = S_DRAIN;
        S_DRAIN:  if (r_drain_cnt) w_next_state = S_OUTPUT;
        S_OUTPUT: if (res_ready && (r_res_idx == IDX_LAST)) w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    res_valid = (r_state == S_OUTPUT);
    res_idx   = r_res_idx;
    done      = r_done;
    dbg_state = r_state;
    res_data  = '0;
    if (r_state == S_OUTPUT) res_data = r_acc[r_res_idx] >> LOG_SAMPLES;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_warm_cnt  <= '0;
      r_samp_cnt  <= '0;
      r_drain_cnt <= 1'b0;
      r_res_idx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last_fire;
      if (w_start_ok) begin
        r_warm_cnt  <= '0;
        r_samp_cnt  <= '0;
        r_drain_cnt <= 1'b0;
      end else begin
        if ((r_state == S_WARMUP) && in_valid) r_warm_cnt <= r_warm_cnt + WCNT_W'(1);
        if (w_accept) r_samp_cnt <= r_samp_cnt + LOG_SAMPLES'(1);
        if (r_state == S_DRAIN) r_drain_cnt <= ~r_drain_cnt;
      end
      // Index returns to 0 after the last result or on abort, so OUTPUT always starts at 0.
      if (abort || w_last_fire) r_res_idx <= '0;
      else if (w_res_fire)      r_res_idx <= r_res_idx + IDX_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
    logic [DATA_WL-1:0] w_cand;
    logic [DATA_WL:0]   w_diff;
    logic [SQ_W-1:0]    w_diff_x;
    logic [ACC_WL:0]    w_sum;

    assign w_cand   = data_in[k*DATA_WL +: DATA_WL];
    assign w_diff   = {w_cand[DATA_WL-1], w_cand} - {data_ref[DATA_WL-1], data_ref};
    // Low SQ_W bits of the product of sign-extended operands equal the signed square.
    assign w_diff_x = {{(DATA_WL+1){w_diff[DATA_WL]}}, w_diff};
    assign w_sq[k]  = w_diff_x * w_diff_x;
    assign w_sum    = {1'b0, r_acc[k]} + {{(ACC_WL+1-SQ_W){1'b0}}, r_sq[k]};
    assign w_acc_next[k] = w_sum[ACC_WL] ? {ACC_WL{1'b1}} : w_sum[ACC_WL-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      for (int k = 0; k < NUM_CAND; k++) begin
        r_sq[k]  <= '0;
        r_acc[k] <= '0;
      end
    end else begin
      r_s1_valid <= w_accept;
      for (int k = 0; k < NUM_CAND; k++) begin
        if (w_accept) r_sq[k] <= w_sq[k];
        if (w_start_ok)      r_acc[k] <= '0;
        else if (r_s1_valid) r_acc[k] <= w_acc_next[k];
      end
    end
  end

endmodule

// File: tb/tb_mse_batch_evaluator.sv
// Directed bench for mse_batch_evaluator: default-parameter batch table plus
// hand sequences for abort, reset, sparse input, stall and saturation.
module tb_mse_batch_evaluator;

  localparam int DW = 12;
  localparam int NC = 2;
  localparam int AW = 64;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // A (defaults) and B (LOG_SAMPLES=4, WARMUP=0) share stimulus except start
  logic          a_start, b_start, abort, in_valid, res_ready;
  logic [NC*DW-1:0] data_in;
  logic [DW-1:0] data_ref;
  logic [AW-1:0] a_res_data, b_res_data, m_res_data;
  logic          a_res_idx, b_res_idx, m_res_idx;
  logic          a_res_valid, b_res_valid, m_res_valid;
  logic          a_busy, b_busy, m_busy;
  logic          a_done, b_done, m_done;
  logic [2:0]    a_state, b_state, m_state;
  logic          sel;

  // C: DATA_WL=32, ACC_WL=66, LOG_SAMPLES=4
  logic          c_start, c_abort, c_in_valid, c_res_ready;
  logic [63:0]   c_data_in;
  logic [31:0]   c_data_ref;
  logic [65:0]   c_res_data;
  logic          c_res_idx, c_res_valid, c_busy, c_done;
  logic [2:0]    c_state;

  mse_batch_evaluator u_dut_a (
    .clk(clk), .rstn(rstn), .start(a_start), .abort(abort), .in_valid(in_valid),
    .data_in(data_in), .data_ref(data_ref), .res_data(a_res_data), .res_idx(a_res_idx),
    .res_valid(a_res_valid), .res_ready(res_ready), .busy(a_busy), .done(a_done),
    .dbg_state(a_state)
  );

  mse_batch_evaluator #(.LOG_SAMPLES(4), .WARMUP(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(b_start), .abort(abort), .in_valid(in_valid),
    .data_in(data_in), .data_ref(data_ref), .res_data(b_res_data), .res_idx(b_res_idx),
    .res_valid(b_res_valid), .res_ready(res_ready), .busy(b_busy), .done(b_done),
    .dbg_state(b_state)
  );

  mse_batch_evaluator #(.DATA_WL(32), .ACC_WL(66), .LOG_SAMPLES(4), .WARMUP(2)) u_dut_c (
    .clk(clk), .rstn(rstn), .start(c_start), .abort(c_abort), .in_valid(c_in_valid),
    .data_in(c_data_in), .data_ref(c_data_ref), .res_data(c_res_data), .res_idx(c_res_idx),
    .res_valid(c_res_valid), .res_ready(c_res_ready), .busy(c_busy), .done(c_done),
    .dbg_state(c_state)
  );

  assign m_res_data  = sel ? b_res_data  : a_res_data;
  assign m_res_idx   = sel ? b_res_idx   : a_res_idx;
  assign m_res_valid = sel ? b_res_valid : a_res_valid;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_done      = sel ? b_done      : a_done;
  assign m_state     = sel ? b_state     : a_state;

  // scoreboard
  int n_vec = 0;
  int n_fail = 0;
  logic [AW-1:0] exp_q[$];

  typedef struct {
    bit            rnd_ref;
    logic [DW-1:0] ref_val;
    int            off0_e, off0_o, off1_e, off1_o;
    int            warm_err;
    bit            stall;
    bit            restart;
    logic [AW-1:0] exp0, exp1;
  } row_t;

  row_t rows[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick_ref(input row_t rw);
    if (rw.rnd_ref) return int'($urandom_range(0, 1800)) - 900;
    return int'($signed(rw.ref_val));
  endfunction

  // driver tasks: entered and left just after a falling edge
  task automatic send_sample(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                             input logic [DW-1:0] r, input bit gaps);
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      data_in  = (NC*DW)'($urandom);
      data_ref = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    data_in  = {c1, c0};
    data_ref = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input bit stall, input string tag);
    int budget;
    int idx;
    logic [AW-1:0] exp_v;
    in_valid  = 1'b1;
    data_in   = (NC*DW)'($urandom);
    data_ref  = DW'($urandom);
    res_ready = !stall;
    budget = 0;
    while (!m_res_valid && budget < 20) begin
      @(negedge clk);
      data_in = (NC*DW)'($urandom);
      budget++;
    end
    check({tag, "_res_valid_rise"}, m_res_valid, 1);
    if (!m_res_valid) begin
      exp_q.delete();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      in_valid = 1'b0;
      res_ready = 1'b1;
      return;
    end
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        check({tag, "_stall_valid"}, m_res_valid, 1);
        check({tag, "_stall_idx"}, m_res_idx, 0);
        check({tag, "_stall_data"}, m_res_data, exp_q[0]);
        @(negedge clk);
      end
      res_ready = 1'b1;
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check({tag, "_valid"}, m_res_valid, 1);
      check({tag, "_idx"}, m_res_idx, idx);
      check({tag, "_data"}, m_res_data, exp_v);
      idx++;
      @(negedge clk);
    end
    check({tag, "_done_pulse"}, m_done, 1);
    check({tag, "_valid_drop"}, m_res_valid, 0);
    check({tag, "_idle"}, m_state, S_IDLE);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, m_done, 0);
    in_valid = 1'b0;
  endtask

  task automatic run_row(input row_t rw, input int ri);
    int rv, c0, c1;
    sel = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rv = pick_ref(rw);
      send_sample(DW'(rv + rw.warm_err), DW'(rv + rw.warm_err), DW'(rv), 1'b1);
    end
    for (int i = 0; i < 1024; i++) begin
      if (rw.restart && i == 500) begin
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
      end
      rv = pick_ref(rw);
      c0 = rv + (((i % 2) == 1) ? rw.off0_o : rw.off0_e);
      c1 = rv + (((i % 2) == 1) ? rw.off1_o : rw.off1_e);
      send_sample(DW'(c0), DW'(c1), DW'(rv), 1'b1);
    end
    exp_q.push_back(rw.exp0);
    exp_q.push_back(rw.exp1);
    collect(rw.stall, $sformatf("row%0d", ri));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv;
    bit seen;
    logic [65:0] sat_exp;

    //          rnd  ref      o0e   o0o   o1e  o1o  warm  stl  rst  exp0      exp1
    rows[0] = '{1'b1, 12'h000, 0,    0,    0,   0,   0,    1'b0, 1'b0, 64'd0,        64'd0};
    rows[1] = '{1'b1, 12'h000, 3,    3,    -5,  -5,  1000, 1'b0, 1'b0, 64'd9,        64'd25};
    rows[2] = '{1'b0, 12'h800, 4095, 4095, 0,   0,   0,    1'b0, 1'b0, 64'd16769025, 64'd0};
    rows[3] = '{1'b1, 12'h000, 1,    2,    3,   -4,  0,    1'b1, 1'b0, 64'd2,        64'd12};
    rows[4] = '{1'b1, 12'h000, -7,   -7,   100, 100, 0,    1'b0, 1'b1, 64'd49,       64'd10000};
    rows[5] = '{1'b1, 12'h000, -30,  10,   -1,  0,   1000, 1'b0, 1'b0, 64'd500,      64'd0};

    sel = 1'b0; a_start = 1'b0; b_start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    res_ready = 1'b1; data_in = '0; data_ref = '0;
    c_start = 1'b0; c_abort = 1'b0; c_in_valid = 1'b0; c_res_ready = 1'b1;
    c_data_in = '0; c_data_ref = '0;

    repeat (3) @(negedge clk);
    check("rst_state", a_state, S_IDLE);
    check("rst_busy", a_busy, 0);
    check("rst_res_valid", a_res_valid, 0);
    check("rst_res_data", a_res_data, 0);
    check("rst_res_idx", a_res_idx, 0);
    check("rst_done", a_done, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_c_res_data", c_res_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) run_row(rows[r], r);

    // start together with abort in IDLE
    a_start = 1'b1; abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0; abort = 1'b0;
    check("start_abort_idle", a_state, S_IDLE);
    check("start_abort_busy", a_busy, 0);

    // abort in ACCUM after 100 samples, then a fresh batch
    sel = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 132; i++) begin
      rv = int'($urandom_range(0, 1800)) - 900;
      send_sample(DW'(rv + 40), DW'(rv - 40), DW'(rv), 1'b0);
    end
    check("abort_pre_accum", a_state, S_ACCUM);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", a_state, S_IDLE);
    check("abort_busy", a_busy, 0);
    check("abort_res_valid", a_res_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      if (a_res_valid || a_done) seen = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("abort_no_result", seen, 0);
    run_row(rows[1], 6);

    // reset in the middle of a batch
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 82; i++) begin
      rv = int'($urandom_range(0, 1800)) - 900;
      send_sample(DW'(rv + 9), DW'(rv), DW'(rv), 1'b0);
    end
    #2 rstn = 1'b0;
    #1;
    check("midrst_state", a_state, S_IDLE);
    check("midrst_busy", a_busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      if (a_res_valid || a_done || a_busy) seen = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midrst_stays_idle", seen, 0);

    // B: sparse in_valid, 16-sample batch, no warm-up
    sel = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("b_start_to_accum", m_state, S_ACCUM);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b0;
      data_in  = (NC*DW)'($urandom);
      data_ref = DW'($urandom);
      @(negedge clk);
      if (i == 15) check("b_accum_before_last", m_state, S_ACCUM);
      rv = int'($urandom_range(0, 1800)) - 900;
      in_valid = 1'b1;
      data_in  = {DW'(rv + 17 - 2*i), DW'(rv + 3*i - 20)};
      data_ref = DW'(rv);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b_drain_after_16", m_state, S_DRAIN);
    exp_q.push_back(64'd197);
    exp_q.push_back(64'd89);
    collect(1'b0, "b_sparse");
    sel = 1'b0;

    // C: saturation at 2^66-1
    sat_exp = {4'h0, {62{1'b1}}};
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      c_in_valid = 1'b1;
      c_data_in  = {32'h8000_0001, 32'h7FFF_FFFF};
      c_data_ref = 32'h8000_0000;
      @(negedge clk);
    end
    c_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!c_res_valid) @(negedge clk);
    end
    check("c_res_valid", c_res_valid, 1);
    check("c_idx0", c_res_idx, 0);
    check("c_sat_data", c_res_data, sat_exp);
    @(negedge clk);
    check("c_idx1", c_res_idx, 1);
    check("c_small_data", c_res_data, 1);
    @(negedge clk);
    check("c_done", c_done, 1);
    check("c_valid_drop", c_res_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
